prll_bs_rr_scheduler: RTL

//  Round-robin scheduler that shares one parallel bus between DRVRS driver FIFOs.
//  - Selects one pending driver, pops its head packet and decodes the destination ID

---
 rtl/prll_bs_sched_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/prll_bs_rr_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/prll_bs_sched_pkg.sv
// Shared types and the destination-ID decode for the parallel-bus round-robin scheduler.
// The decode yields a zero mask for an invalid ID, which the scheduler treats as a drop.
package prll_bs_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    XMIT = 2'd2
  } sched_state_t;

  localparam int CNT_W     = 16;
  localparam int MAX_DRVRS = 16;

  // Broadcast targets every port but the source; direct IDs hit one port (loopback allowed).
  function automatic logic [MAX_DRVRS-1:0] id_to_mask(
    input logic [15:0] id,
    input logic [3:0]  src,
    input int          n,
    input logic [15:0] bcast
  );
    logic [MAX_DRVRS-1:0] m;
    m = '0;
    if (id == bcast) begin
      for (int i = 0; i < MAX_DRVRS; i++) begin
        if (i < n && i != int'(src)) m[4'(i)] = 1'b1;
      end
    end else if (id < 16'(n)) begin
      m[id[3:0]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after 'last', wrapping modulo N.
// No state and no latency; the caller registers the grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  // Scan from the farthest candidate down so the nearest one after 'last' wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[IW'(idx)]) begin
        gnt_idx = IW'(idx);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prll_bs_rr_scheduler.sv
// Shares one parallel bus among DRVRS driver FIFOs: round-robin pop, ID decode, unicast/broadcast push.
// Pop 1 cycle after pending, push 1 cycle after pop; a full target holds the packet in XMIT (all-or-nothing).
module prll_bs_rr_scheduler
  import prll_bs_sched_pkg::*;
#(
  parameter int              DRVRS     = 4,
  parameter int              BITS      = 32,
  parameter int              ID_W      = 8,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DRVRS-1:0]      pndng,
  input  logic [DRVRS*BITS-1:0] D_pop,
  output logic [DRVRS-1:0]      pop,
  input  logic [DRVRS-1:0]      full,
  output logic [DRVRS-1:0]      push,
  output logic [BITS-1:0]       D_push,
  output logic                  busy,
  output logic [CNT_W-1:0]      xfer_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int IW = $clog2(DRVRS);

  sched_state_t     state, state_nxt;
  logic [IW-1:0]    last_grant, grant, arb_idx;
  logic             arb_any;
  logic [BITS-1:0]  heads [DRVRS];
  logic [BITS-1:0]  head, pkt;
  logic [ID_W-1:0]  head_id;
  logic [DRVRS-1:0] dec_mask, tgt;
  logic [DRVRS-1:0] pop_nxt, push_nxt;
  logic             xfer_inc, drop_inc;

  for (genvar i = 0; i < DRVRS; i++) begin : g_heads
    assign heads[i] = D_pop[i*BITS +: BITS];
  end

  assign head     = heads[grant];
  assign head_id  = head[BITS-1 -: ID_W];
  assign dec_mask = DRVRS'(id_to_mask(16'(head_id), 4'(grant), DRVRS, 16'(BROADCAST)));
  assign D_push   = pkt;

  rr_arbiter #(.N(DRVRS), .IW(IW)) u_arb (
    .req     (pndng),
    .last    (last_grant),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // XMIT ends on the cycle the registered push is actually on the bus.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_any) state_nxt = POP;
      POP:     state_nxt = (dec_mask == '0) ? IDLE : XMIT;
      XMIT:    if (push != '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_nxt  = '0;
    push_nxt = '0;
    xfer_inc = 1'b0;
    drop_inc = 1'b0;
    unique case (state)
      IDLE: if (arb_any) pop_nxt = DRVRS'(1) << arb_idx;
      POP: begin
        if (dec_mask == '0) begin
          drop_inc = 1'b1;
        end else if ((dec_mask & full) == '0) begin
          push_nxt = dec_mask;
          xfer_inc = 1'b1;
        end
      end
      XMIT: begin
        if (push == '0 && (tgt & full) == '0) begin
          push_nxt = tgt;
          xfer_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IW'(DRVRS - 1);
      grant      <= '0;
      pkt        <= '0;
      tgt        <= '0;
      pop        <= '0;
      push       <= '0;
      busy       <= 1'b0;
      xfer_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      pop  <= pop_nxt;
      push <= push_nxt;
      busy <= (state_nxt != IDLE);
      if (state == IDLE && arb_any) grant <= arb_idx;
      // Head is sampled on the same edge that consumes it from the FWFT FIFO.
      if (state == POP) begin
        last_grant <= grant;
        if (dec_mask != '0) begin
          pkt <= head;
          tgt <= dec_mask;
        end
      end
      if (xfer_inc && xfer_cnt != '1) xfer_cnt <= xfer_cnt + CNT_W'(1);
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
